// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one uart_tx among NUM_REQ requesters.
// Issues a byte only when the peer is clear to send (cts low) and uart_tx is idle.
// Drops a stalled packet lock after HOLD_TIMEOUT idle cycles.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned HOLD_TIMEOUT = 1200,
    parameter int unsigned TO_W         = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     ack,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   abort,
    input  logic                   cts,
    input  logic                   tx_busy,
    output logic                   tx_start,
    output logic [7:0]             tx_data
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2,
        HOLD      = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic                 abort_q, abort_d;
    logic                 tx_start_q, tx_start_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 lock_q, lock_d;
    logic [TO_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]     last_owner_q, last_owner_d;
    logic [IDX_W-1:0]     owner_q, owner_d;

    logic [IDX_W-1:0]     rr_sel;
    logic [IDX_W-1:0]     issue_idx;
    logic [7:0]           issue_byte;
    logic                 issue_last;
    logic                 do_issue;
    int unsigned          rr_j;

    // Round-robin search starting just after the last owner, wrapping around
    always_comb begin
        rr_sel = last_owner_q;
        rr_j   = 0;
        for (int unsigned i = NUM_REQ; i >= 1; i--) begin
            rr_j = (32'(last_owner_q) + i) % NUM_REQ;
            if (req[IDX_W'(rr_j)]) begin
                rr_sel = IDX_W'(rr_j);
            end
        end
    end

    // Candidate for issue: owner while holding a packet, otherwise the round-robin pick
    always_comb begin
        issue_idx  = (state_q == HOLD) ? owner_q : rr_sel;
        issue_byte = 8'h00;
        issue_last = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == issue_idx) begin
                issue_byte = req_data[8*i +: 8];
                issue_last = req_last[i];
            end
        end
        do_issue = ((state_q == IDLE) || (state_q == HOLD)) &&
                   !cts && !tx_busy && req[issue_idx];
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        ack_d        = '0;
        grant_d      = grant_q;
        abort_d      = 1'b0;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data_q;
        lock_d       = lock_q;
        cnt_d        = cnt_q;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;

        case (state_q)
            IDLE: begin
                grant_d = '0;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (lock_q) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                    end else begin
                        last_owner_d = owner_q;
                        grant_d      = '0;
                        state_d      = IDLE;
                    end
                end
            end
            HOLD: begin
                if (!do_issue && !cts && !req[owner_q]) begin
                    cnt_d = cnt_q + TO_W'(1);
                    if (cnt_d == TO_W'(HOLD_TIMEOUT)) begin
                        abort_d      = 1'b1;
                        lock_d       = 1'b0;
                        last_owner_d = owner_q;
                        grant_d      = '0;
                        cnt_d        = '0;
                        state_d      = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (do_issue) begin
            tx_start_d = 1'b1;
            ack_d      = NUM_REQ'(1) << issue_idx;
            grant_d    = NUM_REQ'(1) << issue_idx;
            tx_data_d  = issue_byte;
            owner_d    = issue_idx;
            lock_d     = !issue_last;
            cnt_d      = '0;
            state_d    = WAIT_BUSY;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            ack_q        <= '0;
            grant_q      <= '0;
            abort_q      <= 1'b0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            lock_q       <= 1'b0;
            cnt_q        <= '0;
            last_owner_q <= IDX_W'(NUM_REQ - 1);
            owner_q      <= '0;
        end else begin
            state_q      <= state_d;
            ack_q        <= ack_d;
            grant_q      <= grant_d;
            abort_q      <= abort_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            lock_q       <= lock_d;
            cnt_q        <= cnt_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
        end
    end

    assign ack      = ack_q;
    assign grant    = grant_q;
    assign abort    = abort_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small uart_tx busy model.
module tb_uart_tx_arbiter;

    localparam int unsigned NUM_REQ  = 4;
    localparam int unsigned HT       = 1200;
    localparam int unsigned BUSY_LEN = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NUM_REQ-1:0]    req;
    logic [8*NUM_REQ-1:0]  req_data;
    logic [NUM_REQ-1:0]    req_last;
    logic [NUM_REQ-1:0]    ack;
    logic [NUM_REQ-1:0]    grant;
    logic                  abort;
    logic                  cts;
    logic                  tx_busy;
    logic                  tx_start;
    logic [7:0]            tx_data;

    int checks   = 0;
    int failures = 0;

    int   busy_cnt   = 0;
    logic force_busy = 1'b0;

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .HOLD_TIMEOUT (HT),
        .TO_W         (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_data (req_data),
        .req_last (req_last),
        .ack      (ack),
        .grant    (grant),
        .abort    (abort),
        .cts      (cts),
        .tx_busy  (tx_busy),
        .tx_start (tx_start),
        .tx_data  (tx_data)
    );

    always #5 clk = ~clk;

    // uart_tx stand-in: busy for BUSY_LEN cycles starting the cycle after tx_start
    always @(posedge clk) begin
        if (tx_start) busy_cnt <= BUSY_LEN;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = force_busy || (busy_cnt != 0);

    task automatic do_reset();
        req = '0; req_last = '0; req_data = '0; cts = 1'b0;
        for (int i = 0; i < 200 && tx_busy; i++) @(negedge clk);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    // Waits (bounded) for an ack; counts cycles where grant differs from hold_g when hold_g != 0
    task automatic wait_ack(input int budget, input logic [NUM_REQ-1:0] hold_g,
                            output int idx, output logic [7:0] d, output int gviol);
        idx = -1; d = 8'h00; gviol = 0;
        for (int c = 0; c < budget && idx < 0; c++) begin
            @(negedge clk);
            if (hold_g != '0 && grant !== hold_g) gviol++;
            if (ack != '0) begin
                for (int k = 0; k < int'(NUM_REQ); k++) if (ack[k]) idx = k;
                d = tx_data;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req = '0; req_last = '0; req_data = '0; cts = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL reset_ack got=%b exp=0000", ack); end
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=0000", grant); end
        checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL reset_tx_start got=%b exp=0", tx_start); end
        checks++; if (abort !== 1'b0) begin failures++; $display("FAIL reset_abort got=%b exp=0", abort); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
        reset = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100; req_data[23:16] = 8'h41; req_last = 4'b0100; cts = 1'b0;
        @(negedge clk);
        checks++; if (tx_start !== 1'b1) begin failures++; $display("FAIL single_tx_start got=%b exp=1", tx_start); end
        checks++; if (ack !== 4'b0100) begin failures++; $display("FAIL single_ack got=%b exp=0100", ack); end
        checks++; if (tx_data !== 8'h41) begin failures++; $display("FAIL single_tx_data got=%h exp=41", tx_data); end
        checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL single_grant got=%b exp=0100", grant); end
        req = '0;
        @(negedge clk);
        checks++; if (tx_start !== 1'b0 || ack !== 4'b0000) begin failures++; $display("FAIL single_pulse got tx_start=%b ack=%b exp 0/0000", tx_start, ack); end
        for (int c = 0; c < 50 && grant != '0; c++) @(negedge clk);
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL single_release got=%b exp=0000", grant); end
    endtask

    task automatic test_round_robin();
        int idx; int gv; logic [7:0] d;
        int exp_idx [5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < int'(NUM_REQ); i++) req_data[8*i +: 8] = 8'(8'h10 + i);
        req_last = '1; req = '1;
        for (int n = 0; n < 5; n++) begin
            wait_ack(100, '0, idx, d, gv);
            checks++; if (idx != exp_idx[n]) begin failures++; $display("FAIL rr_ack[%0d] got=%0d exp=%0d", n, idx, exp_idx[n]); end
            checks++; if (d !== 8'(8'h10 + exp_idx[n])) begin failures++; $display("FAIL rr_data[%0d] got=%h exp=%h", n, d, 8'(8'h10 + exp_idx[n])); end
        end
        req = '0;
    endtask

    task automatic test_packet_lock();
        int idx; int gv; logic [7:0] d;
        do_reset();
        req_data[7:0] = 8'h55; req_last[0] = 1'b1; req = 4'b0001;
        wait_ack(50, '0, idx, d, gv);
        checks++; if (idx != 0) begin failures++; $display("FAIL lock_prime got=%0d exp=0", idx); end
        req_data[15:8] = 8'hA0; req_last[1] = 1'b0; req = 4'b0011;
        wait_ack(100, '0, idx, d, gv);
        checks++; if (idx != 1 || d !== 8'hA0) begin failures++; $display("FAIL lock_b0 got idx=%0d data=%h exp 1/a0", idx, d); end
        req_data[15:8] = 8'hA1;
        wait_ack(100, 4'b0010, idx, d, gv);
        checks++; if (idx != 1 || d !== 8'hA1) begin failures++; $display("FAIL lock_b1 got idx=%0d data=%h exp 1/a1", idx, d); end
        checks++; if (gv != 0) begin failures++; $display("FAIL lock_grant1 got %0d off-owner cycles exp 0", gv); end
        req_data[15:8] = 8'hA2; req_last[1] = 1'b1;
        wait_ack(100, 4'b0010, idx, d, gv);
        checks++; if (idx != 1 || d !== 8'hA2) begin failures++; $display("FAIL lock_b2 got idx=%0d data=%h exp 1/a2", idx, d); end
        checks++; if (gv != 0) begin failures++; $display("FAIL lock_grant2 got %0d off-owner cycles exp 0", gv); end
        req[1] = 1'b0;
        wait_ack(100, '0, idx, d, gv);
        checks++; if (idx != 0 || d !== 8'h55) begin failures++; $display("FAIL lock_next got idx=%0d data=%h exp 0/55", idx, d); end
        req = '0;
    endtask

    task automatic test_cts();
        int bad = 0;
        do_reset();
        cts = 1'b1; req_data[7:0] = 8'h5A; req_last[0] = 1'b1; req = 4'b0001;
        repeat (500) begin
            @(negedge clk);
            if (tx_start || ack != '0) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL cts_block got %0d issue cycles exp 0", bad); end
        cts = 1'b0;
        @(negedge clk);
        checks++; if (tx_start !== 1'b1 || ack !== 4'b0001) begin failures++; $display("FAIL cts_release got tx_start=%b ack=%b exp 1/0001", tx_start, ack); end
        checks++; if (tx_data !== 8'h5A) begin failures++; $display("FAIL cts_data got=%h exp=5a", tx_data); end
        req = '0;
    endtask

    task automatic test_timeout();
        int idx; int gv; logic [7:0] d;
        int abort_at = -1; int n_abort = 0; int n_ack = 0;
        logic [NUM_REQ-1:0] g_at_abort = 'x;
        do_reset();
        req_data[31:24] = 8'hC3; req_last[3] = 1'b0; req = 4'b1000;
        wait_ack(50, '0, idx, d, gv);
        checks++; if (idx != 3) begin failures++; $display("FAIL to_first got=%0d exp=3", idx); end
        req = '0;
        for (int c = 0; c < 50 && !tx_busy; c++) @(negedge clk);
        for (int c = 0; c < 50 && tx_busy; c++) @(negedge clk);
        // Next posedge moves the DUT into HOLD; m counts posedges after that one
        for (int m = 0; m < int'(HT) + 10; m++) begin
            @(negedge clk);
            if (abort) begin
                n_abort++;
                if (abort_at < 0) begin abort_at = m; g_at_abort = grant; end
            end
            if (ack != '0) n_ack++;
        end
        checks++; if (abort_at != int'(HT)) begin failures++; $display("FAIL to_abort_time got=%0d exp=%0d", abort_at, HT); end
        checks++; if (n_abort != 1) begin failures++; $display("FAIL to_abort_pulses got=%0d exp=1", n_abort); end
        checks++; if (n_ack != 0) begin failures++; $display("FAIL to_no_ack got=%0d exp=0", n_ack); end
        checks++; if (g_at_abort !== 4'b0000) begin failures++; $display("FAIL to_grant got=%b exp=0000", g_at_abort); end
        req_data[7:0] = 8'h77; req_last = 4'b1001; req = 4'b1001;
        wait_ack(50, '0, idx, d, gv);
        checks++; if (idx != 0) begin failures++; $display("FAIL to_next got=%0d exp=0", idx); end
        req = '0;

        do_reset();
        req_data[31:24] = 8'hC4; req_last[3] = 1'b0; req = 4'b1000;
        wait_ack(50, '0, idx, d, gv);
        checks++; if (idx != 3) begin failures++; $display("FAIL to_cts_first got=%0d exp=3", idx); end
        req = '0; cts = 1'b1;
        n_abort = 0;
        repeat (HT + 100) begin
            @(negedge clk);
            if (abort) n_abort++;
        end
        checks++; if (n_abort != 0) begin failures++; $display("FAIL to_cts_abort got=%0d exp=0", n_abort); end
        checks++; if (grant !== 4'b1000) begin failures++; $display("FAIL to_cts_grant got=%b exp=1000", grant); end
        cts = 1'b0;
    endtask

    task automatic test_reset_mid();
        int idx; int gv; logic [7:0] d; int bad = 0;
        do_reset();
        req_data[7:0] = 8'h99; req_last[0] = 1'b1; req = 4'b0001;
        wait_ack(50, '0, idx, d, gv);
        checks++; if (idx != 0) begin failures++; $display("FAIL rmid_first got=%0d exp=0", idx); end
        req = '0;
        for (int c = 0; c < 50 && !tx_busy; c++) @(negedge clk);
        @(negedge clk);
        force_busy = 1'b1;
        checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL rmid_pre_grant got=%b exp=0001", grant); end
        #2 reset = 1'b1;
        #1;
        checks++; if (grant !== 4'b0000 || ack !== 4'b0000 || tx_start !== 1'b0 || abort !== 1'b0) begin
            failures++; $display("FAIL rmid_async got grant=%b ack=%b tx_start=%b abort=%b exp all 0", grant, ack, tx_start, abort);
        end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL rmid_tx_data got=%h exp=00", tx_data); end
        @(negedge clk);
        reset = 1'b0;
        req_data[15:8] = 8'h88; req_last = 4'b0011; req = 4'b0011; cts = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (tx_start) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL rmid_busy_block got %0d starts exp 0", bad); end
        force_busy = 1'b0;
        @(negedge clk);
        checks++; if (tx_start !== 1'b1 || ack !== 4'b0001) begin failures++; $display("FAIL rmid_priority got tx_start=%b ack=%b exp 1/0001", tx_start, ack); end
        checks++; if (tx_data !== 8'h99) begin failures++; $display("FAIL rmid_data got=%h exp=99", tx_data); end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_packet_lock();
        test_cts();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
